// File: rtl/lvds_rx_pkg.sv
// -----------------------------------------------------------------------------
// lvds_rx_pkg
// Shared definitions for the LVDS I/Q frame receiver:
//   I_SYNC / Q_SYNC : sync dibits leading the I and Q half-frames
//   rx_state_e      : receiver FSM state encoding
//   field_w()       : bits per I (or Q) field for a given sample width
//                     (2 sync bits + SAMPLE_W data bits + 1 ctrl bit)
// -----------------------------------------------------------------------------
package lvds_rx_pkg;

  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_I_PHASE = 2'd1,
    S_Q_SYNC  = 2'd2,
    S_Q_PHASE = 2'd3
  } rx_state_e;

  function automatic int field_w(input int sample_w);
    return sample_w + 3;
  endfunction

endpackage

// File: rtl/lvds_rx_sat_cnt.sv
// -----------------------------------------------------------------------------
// lvds_rx_sat_cnt
// Saturating event counter clocked on the falling edge of the DDR clock.
//   clk_i   : clock (falling edge active)
//   rst_ni  : asynchronous active-low reset, clears count
//   inc_i   : increment enable, ignored once count is all-ones
//   cnt_o   : current count
// -----------------------------------------------------------------------------
module lvds_rx_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        cnt_q <= '0;
    else if (inc_i && (cnt_q != '1))    cnt_q <= cnt_q + CNT_W'(1);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lvds_rx_iq.sv
// -----------------------------------------------------------------------------
// lvds_rx_iq
// LVDS I/Q frame receiver. Deserialises DDR dibits (MSB first) into frames
// {I_SYNC, I_DATA, I_CTRL, Q_SYNC, Q_DATA, Q_CTRL}, verifies both sync
// patterns, tracks frame lock and pushes completed words into the RX FIFO.
// All flops update on the falling edge of i_ddr_clk.
//
// Ports:
//   i_ddr_clk        : sole clock (falling edge active)
//   i_reset_n        : asynchronous active-low reset
//   i_enable         : receiver enable; low forces HUNT and drops lock
//   i_ddr_data       : DDR dibit, MSB first in time
//   i_fifo_full      : RX FIFO full, sampled on frame-completion edge only
//   o_fifo_write_clk : FIFO write clock (= i_ddr_clk)
//   o_fifo_push      : one-cycle write strobe
//   o_fifo_data      : last completed frame, first dibit at MSBs
//   o_locked         : frame lock status
//   o_drop_cnt       : locked frames lost to FIFO full (saturating)
//   o_sync_err_cnt   : sync-pattern errors (saturating)
//
// Build option: define LVDS_RX_STATS_EN to implement the two statistics
// counters; otherwise they read as constant zero.
// -----------------------------------------------------------------------------
module lvds_rx_iq
  import lvds_rx_pkg::*;
#(
  parameter int SAMPLE_W = 13,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 16,
  localparam int FIELD   = field_w(SAMPLE_W),
  localparam int FRAME_W = 2 * FIELD
) (
  input  logic               i_ddr_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic [1:0]         i_ddr_data,
  input  logic               i_fifo_full,
  output logic               o_fifo_write_clk,
  output logic               o_fifo_push,
  output logic [FRAME_W-1:0] o_fifo_data,
  output logic               o_locked,
  output logic [CNT_W-1:0]   o_drop_cnt,
  output logic [CNT_W-1:0]   o_sync_err_cnt
);

  localparam int HALF = FIELD / 2;
  localparam int PH_W = (HALF > 2) ? $clog2(HALF) : 1;
  // Index of the last data dibit within a half-frame phase (H-1 dibits).
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(HALF - 2);
  localparam logic [7:0]      LOCK_TGT = 8'(LOCK_CNT);

  rx_state_e            state_q, state_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [7:0]           good_q, good_d;
  logic                 locked_q, locked_d;
  logic                 push_q, push_d;
  logic [FRAME_W-1:0]   data_q, data_d;
  // Holds the last FIELD-1 dibits; a whole frame shifts exactly that many
  // before its final dibit, so no clearing between frames is required.
  logic [FRAME_W-3:0]   sr_q, sr_d;
  logic                 err_inc, drop_inc;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    good_d   = good_q;
    locked_d = locked_q;
    push_d   = 1'b0;
    data_d   = data_q;
    err_inc  = 1'b0;
    drop_inc = 1'b0;
    sr_d     = {sr_q[FRAME_W-5:0], i_ddr_data};

    if (!i_enable) begin
      state_d  = S_HUNT;
      ph_d     = '0;
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        S_HUNT: begin
          if (i_ddr_data == I_SYNC) begin
            state_d = S_I_PHASE;
            ph_d    = '0;
          end else if (locked_q) begin
            // While locked we only sit in HUNT for the dibit right after a
            // completed frame, so anything but a new I sync breaks cadence.
            err_inc  = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
          end
        end

        S_I_PHASE: begin
          if (ph_q == PH_LAST) begin
            state_d = S_Q_SYNC;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end

        S_Q_SYNC: begin
          ph_d = '0;
          if (i_ddr_data == Q_SYNC) begin
            state_d = S_Q_PHASE;
          end else begin
            err_inc  = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
            // A misplaced I sync restarts a frame on this very dibit.
            state_d  = (i_ddr_data == I_SYNC) ? S_I_PHASE : S_HUNT;
          end
        end

        S_Q_PHASE: begin
          if (ph_q == PH_LAST) begin
            state_d  = S_HUNT;
            ph_d     = '0;
            data_d   = {sr_q, i_ddr_data};
            good_d   = (good_q >= LOCK_TGT) ? good_q : good_q + 8'd1;
            locked_d = (good_d >= LOCK_TGT);
            push_d   = locked_d & ~i_fifo_full;
            drop_inc = locked_d &  i_fifo_full;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end

        default: state_d = S_HUNT;
      endcase
    end
  end

  always_ff @(negedge i_ddr_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_HUNT;
      ph_q     <= '0;
      good_q   <= '0;
      locked_q <= 1'b0;
      push_q   <= 1'b0;
      data_q   <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      push_q   <= push_d;
      data_q   <= data_d;
      sr_q     <= sr_d;
    end
  end

  assign o_fifo_write_clk = i_ddr_clk;
  assign o_fifo_push      = push_q;
  assign o_fifo_data      = data_q;
  assign o_locked         = locked_q;

`ifdef LVDS_RX_STATS_EN
  lvds_rx_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk_i  (i_ddr_clk),
    .rst_ni (i_reset_n),
    .inc_i  (drop_inc),
    .cnt_o  (o_drop_cnt)
  );

  lvds_rx_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk_i  (i_ddr_clk),
    .rst_ni (i_reset_n),
    .inc_i  (err_inc),
    .cnt_o  (o_sync_err_cnt)
  );
`else
  logic stats_unused;
  assign stats_unused   = err_inc ^ drop_inc;
  assign o_drop_cnt     = '0;
  assign o_sync_err_cnt = '0;
`endif

endmodule

// File: tb/tb_lvds_rx_iq.sv
module tb_lvds_rx_iq;

`ifdef LVDS_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b1;
  logic        rst_n, en, full0;
  logic [1:0]  d0, d1;

  logic        wclk0, push0, lock0;
  logic [31:0] data0;
  logic [15:0] drop0, err0;

  logic        wclk1, push1, lock1;
  logic [27:0] data1;
  logic [1:0]  drop1, err1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  lvds_rx_iq dut0 (
    .i_ddr_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_ddr_data(d0),
    .i_fifo_full(full0), .o_fifo_write_clk(wclk0), .o_fifo_push(push0),
    .o_fifo_data(data0), .o_locked(lock0), .o_drop_cnt(drop0),
    .o_sync_err_cnt(err0)
  );

  lvds_rx_iq #(.SAMPLE_W(11), .LOCK_CNT(4), .CNT_W(2)) dut1 (
    .i_ddr_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_ddr_data(d1),
    .i_fifo_full(1'b0), .o_fifo_write_clk(wclk1), .o_fifo_push(push1),
    .o_fifo_data(data1), .o_locked(lock1), .o_drop_cnt(drop1),
    .o_sync_err_cnt(err1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Frames are held left-aligned in 64 bits so dibit k is w[63-2k -: 2].
  function automatic logic [63:0] pack13(input logic [12:0] id, input logic [12:0] qd,
                                         input logic ic, input logic qc);
    return {2'b10, id, ic, 2'b01, qd, qc, 32'b0};
  endfunction

  function automatic logic [63:0] pack11(input logic [10:0] id, input logic [10:0] qd,
                                         input logic ic, input logic qc);
    return {2'b10, id, ic, 2'b01, qd, qc, 36'b0};
  endfunction

  task automatic tick(input logic [1:0] v, input bit sel);
    if (sel) d1 = v; else d0 = v;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w, input int first, input int n, input bit sel);
    for (int k = first; k < first + n; k++) tick(w[63-2*k -: 2], sel);
  endtask

  initial begin
    logic [63:0] wa, wb, wc, wd;
    wa = pack13(13'h0ABC, 13'h1234, 1'b0, 1'b0);
    wb = pack13(13'h1555, 13'h0AAA, 1'b1, 1'b0);
    wc = pack13(13'h0F0F, 13'h10F1, 1'b0, 1'b1);
    wd = pack11(11'h2A5, 11'h13C, 1'b1, 1'b0);

    rst_n = 1'b0; en = 1'b1; full0 = 1'b0; d0 = 2'b00; d1 = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_push",   {63'b0, push0}, 64'd0);
    chk("reset_data",   {32'b0, data0}, 64'd0);
    chk("reset_lock",   {63'b0, lock0}, 64'd0);
    chk("reset_drop",   {48'b0, drop0}, 64'd0);
    chk("reset_err",    {48'b0, err0},  64'd0);
    chk("write_clk",    {63'b0, wclk0}, {63'b0, clk});
    rst_n = 1'b1;

    // Lock acquisition: frames 1..3 complete but are not pushed.
    for (int f = 1; f <= 3; f++) begin
      send(wa, 0, 16, 0);
      chk("unlocked_push", {63'b0, push0}, 64'd0);
      chk("unlocked_lock", {63'b0, lock0}, 64'd0);
    end
    send(wa, 0, 16, 0);
    chk("f4_push", {63'b0, push0}, 64'd1);
    chk("f4_data", {32'b0, data0}, 64'h95786468);
    chk("f4_lock", {63'b0, lock0}, 64'd1);
    send(wc, 0, 1, 0);
    chk("push_one_cycle", {63'b0, push0}, 64'd0);
    chk("data_hold", {32'b0, data0}, 64'h95786468);
    send(wc, 1, 15, 0);
    chk("f5_push", {63'b0, push0}, 64'd1);
    chk("f5_data", {32'b0, data0}, {32'b0, wc[63:32]});

    // Bad Q sync (2'b11) while locked.
    send(wa, 0, 8, 0);
    tick(2'b11, 0);
    chk("qs11_lock", {63'b0, lock0}, 64'd0);
    chk("qs11_push", {63'b0, push0}, 64'd0);
    chk("qs11_err",  {48'b0, err0}, STATS ? 64'd1 : 64'd0);
    tick(2'b00, 0);
    tick(2'b00, 0);
    chk("idle_unlocked_err", {48'b0, err0}, STATS ? 64'd1 : 64'd0);
    for (int f = 1; f <= 3; f++) send(wa, 0, 16, 0);
    chk("relock3_lock", {63'b0, lock0}, 64'd0);
    send(wa, 0, 16, 0);
    chk("relock4_lock", {63'b0, lock0}, 64'd1);
    chk("relock4_push", {63'b0, push0}, 64'd1);

    // Q sync slot carries an I sync: error, and that dibit opens a new frame.
    send(wa, 0, 8, 0);
    tick(2'b10, 0);
    chk("qs10_lock", {63'b0, lock0}, 64'd0);
    chk("qs10_err",  {48'b0, err0}, STATS ? 64'd2 : 64'd0);
    send(wb, 1, 15, 0);
    chk("qs10_data", {32'b0, data0}, {32'b0, wb[63:32]});
    chk("qs10_push", {63'b0, push0}, 64'd0);
    for (int f = 1; f <= 3; f++) send(wa, 0, 16, 0);
    chk("qs10_relock", {63'b0, lock0}, 64'd1);
    chk("qs10_relock_push", {63'b0, push0}, 64'd1);

    // FIFO full for three locked frames.
    full0 = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      send(wa, 0, 16, 0);
      chk("full_push", {63'b0, push0}, 64'd0);
    end
    chk("full_drop", {48'b0, drop0}, STATS ? 64'd3 : 64'd0);
    chk("full_lock", {63'b0, lock0}, 64'd1);
    full0 = 1'b0;
    send(wb, 0, 16, 0);
    chk("unfull_push", {63'b0, push0}, 64'd1);
    chk("unfull_data", {32'b0, data0}, {32'b0, wb[63:32]});

    // Missing I sync right after a locked frame.
    tick(2'b00, 0);
    chk("hunt_err",  {48'b0, err0}, STATS ? 64'd3 : 64'd0);
    chk("hunt_lock", {63'b0, lock0}, 64'd0);
    tick(2'b00, 0);
    chk("hunt_err_once", {48'b0, err0}, STATS ? 64'd3 : 64'd0);
    for (int f = 1; f <= 4; f++) send(wa, 0, 16, 0);
    chk("hunt_relock", {63'b0, lock0}, 64'd1);

    // Enable low drops lock but keeps statistics.
    en = 1'b0;
    tick(2'b10, 0);
    tick(2'b00, 0);
    chk("dis_lock", {63'b0, lock0}, 64'd0);
    chk("dis_push", {63'b0, push0}, 64'd0);
    chk("dis_drop", {48'b0, drop0}, STATS ? 64'd3 : 64'd0);
    chk("dis_err",  {48'b0, err0},  STATS ? 64'd3 : 64'd0);
    en = 1'b1;

    // Relock, then reset at dibit 5 of I_PHASE.
    for (int f = 1; f <= 4; f++) send(wc, 0, 16, 0);
    chk("pre_rst_lock", {63'b0, lock0}, 64'd1);
    send(wa, 0, 6, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data", {32'b0, data0}, 64'd0);
    chk("rst_lock", {63'b0, lock0}, 64'd0);
    chk("rst_err",  {48'b0, err0},  64'd0);
    chk("rst_drop", {48'b0, drop0}, 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int f = 1; f <= 3; f++) send(wa, 0, 16, 0);
    chk("post_rst_lock3", {63'b0, lock0}, 64'd0);
    send(wa, 0, 16, 0);
    chk("post_rst_lock4", {63'b0, lock0}, 64'd1);
    chk("post_rst_push4", {63'b0, push0}, 64'd1);
    chk("post_rst_data4", {32'b0, data0}, 64'h95786468);

    // SAMPLE_W=11 instance: 28-bit frames, 14-cycle cadence, 2-bit counters.
    d0 = 2'b00;
    for (int f = 1; f <= 3; f++) send(wd, 0, 14, 1);
    chk("w11_lock3", {63'b0, lock1}, 64'd0);
    send(wd, 0, 14, 1);
    chk("w11_push4", {63'b0, push1}, 64'd1);
    chk("w11_data4", {36'b0, data1}, {36'b0, wd[63:36]});
    send(wd, 0, 13, 1);
    chk("w11_gap", {63'b0, push1}, 64'd0);
    send(wd, 13, 1, 1);
    chk("w11_push5", {63'b0, push1}, 64'd1);
    for (int e = 1; e <= 5; e++) begin
      send(wd, 0, 7, 1);
      tick(2'b11, 1);
      chk("w11_err_sat", {62'b0, err1}, STATS ? ((e > 3) ? 64'd3 : 64'(e)) : 64'd0);
    end
    chk("w11_lock_lost", {63'b0, lock1}, 64'd0);
    chk("w11_drop", {62'b0, drop1}, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout: simulation did not finish");
  end

endmodule
